// File: rtl/sixteen_bit_rca.sv
// ============================================================================
// Module   : sixteen_bit_rca
// Purpose  : Ripple-carry adder with registered sum and carry-out.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sixteen_bit_rca #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             cin,
  output logic [WIDTH-1:0] Output,
  output logic             cout
);

  logic [WIDTH:0]   w_c;
  logic [WIDTH-1:0] w_s;

  assign w_c[0] = cin;

  // One full-adder cell per bit; the carry ripples through the chain.
  for (genvar i = 0; i < WIDTH; i++) begin : g_fa
    assign w_s[i]   = A[i] ^ B[i] ^ w_c[i];
    assign w_c[i+1] = (A[i] & B[i]) | (A[i] & w_c[i]) | (B[i] & w_c[i]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      Output <= '0;
      cout   <= 1'b0;
    end else begin
      Output <= w_s;
      cout   <= w_c[WIDTH];
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_sixteen_bit_rca.sv
// ============================================================================
// Module   : tb_sixteen_bit_rca
// Purpose  : Self-checking bench for sixteen_bit_rca against an arithmetic model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sixteen_bit_rca;

  logic        clk;
  logic        rst_n;
  logic [15:0] A;
  logic [15:0] B;
  logic        cin;
  logic [15:0] Output;
  logic        cout;

  int checks;
  int errors;
  logic [16:0] last_exp;

  sixteen_bit_rca #(.WIDTH(16)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .A      (A),
    .B      (B),
    .cin    (cin),
    .Output (Output),
    .cout   (cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [16:0] model(input logic [15:0] a, input logic [15:0] b,
                                       input logic c);
    return 17'(a) + 17'(b) + 17'(c);
  endfunction

  task automatic drive(input logic [15:0] a, input logic [15:0] b, input logic c);
    A   = a;
    B   = b;
    cin = c;
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    drive(16'($urandom), 16'($urandom), 1'($urandom));
    #3 rst_n = 1'b0;
    #1;
    checks++;
    if ({cout, Output} !== 17'h0_0000) begin
      errors++;
      $display("FAIL reset_async got=%h exp=%h", {cout, Output}, 17'h0_0000);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    drive(16'h0000, 16'h0000, 1'b0);
    @(posedge clk);
    #1;
    checks++;
    if ({cout, Output} !== 17'h0_0000) begin
      errors++;
      $display("FAIL reset_first_add got=%h exp=%h", {cout, Output}, 17'h0_0000);
    end
    last_exp = 17'h0_0000;
  endtask

  task automatic test_corners();
    logic [15:0] ta [6] = '{16'hFFFF, 16'hFFFF, 16'h5555, 16'h5555, 16'h270F, 16'h1234};
    logic [15:0] tb [6] = '{16'h0001, 16'hFFFF, 16'hAAAA, 16'hAAAA, 16'h270F, 16'h4321};
    logic        tc [6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    logic [16:0] te [6] = '{17'h1_0000, 17'h1_FFFF, 17'h1_0000, 17'h0_FFFF,
                            17'h0_4E1E, 17'h0_5556};
    for (int i = 0; i < 6; i++) begin
      drive(ta[i], tb[i], tc[i]);
      @(posedge clk);
      #1;
      checks++;
      if ({cout, Output} !== te[i]) begin
        errors++;
        $display("FAIL corner_%0d A=%h B=%h cin=%b got=%h exp=%h",
                 i, ta[i], tb[i], tc[i], {cout, Output}, te[i]);
      end
      last_exp = te[i];
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] ta [3] = '{16'h0001, 16'h8000, 16'h7FFF};
    logic [15:0] tb [3] = '{16'h0001, 16'h8000, 16'h0001};
    logic [16:0] te [3] = '{17'h0_0002, 17'h1_0000, 17'h0_8000};
    for (int i = 0; i < 3; i++) begin
      drive(ta[i], tb[i], 1'b0);
      #1;
      checks++;
      if ({cout, Output} !== last_exp) begin
        errors++;
        $display("FAIL b2b_hold_%0d got=%h exp=%h", i, {cout, Output}, last_exp);
      end
      @(posedge clk);
      #1;
      checks++;
      if ({cout, Output} !== te[i]) begin
        errors++;
        $display("FAIL b2b_result_%0d got=%h exp=%h", i, {cout, Output}, te[i]);
      end
      last_exp = te[i];
    end
  endtask

  task automatic test_reset_midstream();
    drive(16'h0001, 16'h0001, 1'b0);
    @(posedge clk);
    #1;
    checks++;
    if ({cout, Output} !== 17'h0_0002) begin
      errors++;
      $display("FAIL mid_pre got=%h exp=%h", {cout, Output}, 17'h0_0002);
    end
    drive(16'h8000, 16'h8000, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({cout, Output} !== 17'h0_0000) begin
      errors++;
      $display("FAIL mid_async got=%h exp=%h", {cout, Output}, 17'h0_0000);
    end
    @(posedge clk);
    #1;
    checks++;
    if ({cout, Output} !== 17'h0_0000) begin
      errors++;
      $display("FAIL mid_held got=%h exp=%h", {cout, Output}, 17'h0_0000);
    end
    drive(16'h7FFF, 16'h0001, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if ({cout, Output} !== 17'h0_0000) begin
      errors++;
      $display("FAIL mid_release got=%h exp=%h", {cout, Output}, 17'h0_0000);
    end
    @(posedge clk);
    #1;
    checks++;
    if ({cout, Output} !== 17'h0_8000) begin
      errors++;
      $display("FAIL mid_after got=%h exp=%h", {cout, Output}, 17'h0_8000);
    end
    last_exp = 17'h0_8000;
  endtask

  task automatic test_random();
    logic [15:0] a;
    logic [15:0] b;
    logic        c;
    logic [16:0] exp;
    for (int i = 0; i < 1000; i++) begin
      a = 16'($urandom);
      b = 16'($urandom);
      c = 1'($urandom);
      drive(a, b, c);
      exp = model(a, b, c);
      @(posedge clk);
      #1;
      checks++;
      if ({cout, Output} !== exp) begin
        errors++;
        $display("FAIL random_%0d A=%h B=%h cin=%b got=%h exp=%h",
                 i, a, b, c, {cout, Output}, exp);
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    last_exp = '0;
    test_reset();
    test_corners();
    test_back_to_back();
    test_reset_midstream();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
